// File: rtl/binary_to_bcd_12bit.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_12bit
// Description : Iterative double-dabble converter, 12-bit binary to 4 BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_12bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_CONVERT   = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam logic [3:0] c_LAST_ITER = 4'd11;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [11:0] r_shift;
    logic [15:0] r_scratch;
    logic [3:0]  r_count;
    logic [15:0] r_digits;
    logic [15:0] w_adj;
    logic [15:0] w_next_scratch;
    logic [11:0] w_next_shift;
    logic        w_last;

    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 :
                                 r_scratch[4*g +: 4];
    end

    // The adjusted thousands nibble never reaches bit 15, so its carry-out is safely dropped.
    assign w_next_scratch = (w_adj << 1) | {15'd0, r_shift[11]};
    assign w_next_shift   = r_shift << 1;
    assign w_last         = (r_state == c_CONVERT) && (r_count == c_LAST_ITER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_next = c_CONVERT;
            c_CONVERT: if (w_last) w_state_next = c_DONE;
            c_DONE:    w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_CONVERT: busy = 1'b1;
            c_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= 12'd0;
            r_scratch <= 16'd0;
            r_count   <= 4'd0;
            r_digits  <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift   <= bin_in;
                        r_scratch <= 16'd0;
                        r_count   <= 4'd0;
                    end
                end
                c_CONVERT: begin
                    r_shift   <= w_next_shift;
                    r_scratch <= w_next_scratch;
                    r_count   <= r_count + 4'd1;
                    if (w_last) r_digits <= w_next_scratch;
                end
                default: ;
            endcase
        end
    end

    assign thousands = r_digits[15:12];
    assign hundreds  = r_digits[11:8];
    assign tens      = r_digits[7:4];
    assign ones      = r_digits[3:0];

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_12bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_to_bcd_12bit
// Description : Self-checking bench for binary_to_bcd_12bit against a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_to_bcd_12bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bin_in;
    logic        busy;
    logic        done;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;

    int          n_checks;
    int          n_errors;
    logic [15:0] last_exp;

    binary_to_bcd_12bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Decimal reference: digits straight from integer division.
    function automatic logic [15:0] bcd_of(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    // One full conversion with a one-cycle start pulse; bin_in is scrambled after acceptance.
    task automatic run_conv(input int v);
        logic [15:0] exp;
        int          n;
        bit          seen;
        exp    = bcd_of(v);
        bin_in = v[11:0];
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 12'($urandom);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_busy v=%0d: busy=%b expected 1", v, busy);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            n_checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                n_errors++;
                $display("FAIL busy_done_overlap v=%0d cycle %0d: both high", v, n);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                n_checks++;
                if (digits() !== last_exp) begin
                    n_errors++;
                    $display("FAIL digits_hold v=%0d cycle %0d: got %h expected %h", v, n, digits(), last_exp);
                end
                if (n < 12) begin
                    n_checks++;
                    if (busy !== 1'b1) begin
                        n_errors++;
                        $display("FAIL busy_high v=%0d cycle %0d: busy=%b expected 1", v, n, busy);
                    end
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL done_timeout v=%0d: no done within 20 cycles", v);
        end
        n_checks++;
        if (n != 12) begin
            n_errors++;
            $display("FAIL latency v=%0d: done after %0d cycles expected 12", v, n);
        end
        n_checks++;
        if (digits() !== exp) begin
            n_errors++;
            $display("FAIL result v=%0d: got %h expected %h", v, digits(), exp);
        end
        last_exp = exp;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL return_idle v=%0d: done=%b busy=%b expected 0 0", v, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        bin_in = 12'd4095;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || digits() !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b digits=%h expected 0 0 0000", busy, done, digits());
        end
        start    = 1'b0;
        rst_n    = 1'b1;
        last_exp = 16'h0000;
    endtask

    task automatic test_directed();
        int          vals [5] = '{273, 999, 2048, 1, 1234};
        logic [15:0] exps [5] = '{16'h0273, 16'h0999, 16'h2048, 16'h0001, 16'h1234};
        for (int i = 0; i < 5; i++) begin
            run_conv(vals[i]);
            n_checks++;
            if (digits() !== exps[i]) begin
                n_errors++;
                $display("FAIL directed %0d: got %h expected %h", vals[i], digits(), exps[i]);
            end
        end
    endtask

    task automatic test_boundary();
        run_conv(0);
        n_checks++;
        if (digits() !== 16'h0000) begin
            n_errors++;
            $display("FAIL boundary_0: got %h expected 0000", digits());
        end
        run_conv(4095);
        n_checks++;
        if (digits() !== 16'h4095) begin
            n_errors++;
            $display("FAIL boundary_4095: got %h expected 4095", digits());
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        bin_in = 12'd2048;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 12'($urandom);
        ndone  = 0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL swb_busy E0: busy=%b expected 1", busy);
        end
        for (int e = 1; e <= 16; e++) begin
            if (e == 4) begin
                start  = 1'b1;
                bin_in = 12'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (e <= 11) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL swb_busy E%0d: busy=%b expected 1", e, busy);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                n_checks++;
                if (e != 12 || digits() !== 16'h2048) begin
                    n_errors++;
                    $display("FAIL swb_result E%0d: got %h expected 2048 at E12", e, digits());
                end
            end
        end
        n_checks++;
        if (ndone != 1) begin
            n_errors++;
            $display("FAIL swb_done_count: got %0d expected 1", ndone);
        end
        last_exp = 16'h2048;
    endtask

    task automatic test_reset_mid();
        run_conv(1234);
        bin_in = 12'd999;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            if (e == 6) rst_n = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid_done E%0d: done=%b expected 0", e, done);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || digits() !== 16'h0000) begin
            n_errors++;
            $display("FAIL rst_mid_clear: busy=%b digits=%h expected 0 0000", busy, digits());
        end
        rst_n    = 1'b1;
        last_exp = 16'h0000;
        // The restart is sampled on the very first edge with reset released.
        run_conv(999);
    endtask

    task automatic test_back_to_back();
        int vals [72];
        for (int i = 0; i < 72; i++) vals[i] = int'($urandom_range(0, 4095));
        bin_in = vals[0][11:0];
        start  = 1'b1;
        for (int e = 0; e < 70; e++) begin
            @(posedge clk); #1;
            bin_in = vals[e + 1][11:0];
            n_checks++;
            if ((e % 14) == 12) begin
                if (done !== 1'b1 || digits() !== bcd_of(vals[e - 12])) begin
                    n_errors++;
                    $display("FAIL b2b edge %0d: done=%b digits=%h expected 1 %h", e, done, digits(), bcd_of(vals[e - 12]));
                end
            end else if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b edge %0d: done=%b expected 0", e, done);
            end
        end
        start    = 1'b0;
        last_exp = bcd_of(vals[56]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            run_conv(int'($urandom_range(0, 4095)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_exp = 16'h0000;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin_in   = 12'd0;
        test_reset();
        test_directed();
        test_boundary();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
